sc_proc_mem_seq: RTL and testbench
==================================

SC_PROC_MEM_SEQ -- requirements
Module: sc_proc_mem_seq

Interface
REQ-001 Parameter DBITS, default 32, datapath and memory word width.
REQ-002 Parameter TIMEOUT, default 255, maximum wait cycles per memory access before an error is flagged.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 pcOut  input  DBITS  current PC; used as the fetch address.
REQ-006 isMemOp  input  1  decoded instruction is LW or SW; valid in EXEC.
REQ-007 isSW  input  1  decoded instruction is SW; valid in EXEC.
REQ-008 dAddr, dWdata  input  DBITS each  data address and store data from the datapath; valid in EXEC.
REQ-009 halt  input  1  request to stop after the current instruction commits.
REQ-010 memReq, memWe  output  1 each  request to the shared memory port, and its write qualifier.
REQ-011 memAddr, memWdata  output  DBITS each  port address and write data.
REQ-012 memRdata  input  DBITS; memReady  input  1  read data and completion handshake.
REQ-013 instr  output  DBITS  latched instruction word.
REQ-014 outMem  output  DBITS  latched load data.
REQ-015 lock  output  1  commit strobe that enables register-file, memory and PC writes.
REQ-016 halted, memErr  output  1 each  sticky halt and timeout flags.
REQ-017 retired  output  32  count of committed instructions.

Function
REQ-018 The FSM SHALL have exactly five states: FETCH, EXEC, DATA, COMMIT and HALT.
REQ-019 FETCH: memReq=1, memWe=0, memAddr=pcOut; on memReady, instr<=memRdata and go to EXEC.
REQ-020 EXEC lasts exactly 1 cycle with memReq=0; next state is DATA if isMemOp, otherwise COMMIT.
REQ-021 On leaving EXEC, dAddr, dWdata and isSW SHALL be captured into internal registers.
REQ-022 DATA: memReq=1, memAddr=captured dAddr, memWe=captured isSW, memWdata=captured dWdata.
REQ-023 In DATA, on memReady: if the captured isSW is 0, outMem<=memRdata; then go to COMMIT.
REQ-024 COMMIT: lock=1 for exactly one cycle and retired increments by 1, wrapping from 0xFFFFFFFF to 0.
REQ-025 From COMMIT, the next state is HALT if halt is 1 in the COMMIT cycle, otherwise FETCH.
REQ-026 HALT is absorbing until reset: halted=1, memReq=0, lock=0.
REQ-027 memReq, memWe, memAddr and memWdata SHALL hold stable from assertion until the memReady cycle.
REQ-028 memReq SHALL drop in the cycle after memReady is accepted.
REQ-029 memReady sampled while memReq=0 SHALL be ignored.
REQ-030 lock SHALL be 0 in every state except COMMIT.
REQ-031 Minimum instruction latency SHALL be 3 cycles for ALU/branch instructions and 4 cycles for memory instructions, with zero-wait memory.
REQ-032 A 9-bit wait counter SHALL clear on entry to FETCH or DATA and increment each cycle that memReady=0.
REQ-033 If the wait counter reaches TIMEOUT, memErr SHALL be set sticky, the access SHALL be abandoned and the FSM SHALL go to HALT without a commit.
REQ-034 halt asserted in any state other than COMMIT SHALL NOT interrupt the current instruction; it is acted on only if still high at COMMIT.
REQ-035 memReady and timeout in the same cycle: memReady wins and the access completes normally.

Reset
REQ-036 While reset_n=0, at the next rising edge: state<=FETCH; instr, outMem, retired and the wait counter <=0; halted, memErr <=0.
REQ-037 During reset cycles, memReq and lock SHALL be 0.
REQ-038 The first memReq SHALL be asserted in the first cycle with reset_n=1.
REQ-039 Reset asserted mid-access SHALL abandon the access with no commit, and the pending memReady SHALL be ignored.

Structure
REQ-040 The state encoding (3-bit) and the default TIMEOUT SHALL live in the shared processor package.
REQ-041 The memory-port mux and FSM SHALL be a single module.
REQ-042 The wait counter SHALL be one sub-module, sc_proc_wait_timer (inputs clear/tick, output expired).

Verification
REQ-043 Zero-wait memory, 3 ALU instructions -> lock pulses at cycles 3, 6 and 9 after reset release; retired=3.
REQ-044 LW with memReady delayed 2 cycles in DATA -> memAddr=dAddr held 3 cycles, outMem=memRdata, lock once, memWe=0.
REQ-045 SW with dAddr=0x100 and dWdata=0xDEADBEEF -> memWe=1 with that address and data for 1 cycle; outMem unchanged.
REQ-046 memReady never returns in FETCH, TIMEOUT=8 -> memErr=1 and halted=1 after 9 cycles; lock never pulses.
REQ-047 halt pulsed in EXEC only -> no halt; halt held through COMMIT -> HALT entered; memReq stays 0 thereafter.
REQ-048 reset_n low during DATA wait -> next cycle is FETCH-after-reset; retired=0; late memReady is ignored.

Source files
------------

// File: rtl/sc_proc_mem_seq_pkg.sv
// Shared definitions for the single-port processor memory sequencer: state
// encoding, wait-counter width and the default access timeout.
package sc_proc_mem_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_FETCH  = 3'd0;
  localparam state_t ST_EXEC   = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_COMMIT = 3'd3;
  localparam state_t ST_HALT   = 3'd4;

  localparam int unsigned WAIT_W          = 9;
  localparam int unsigned DEFAULT_TIMEOUT = 255;

  // States that own the shared memory port.
  function automatic logic is_access(input state_t s);
    return (s == ST_FETCH) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/sc_proc_mem_seq_wait_timer.sv
// Per-access wait counter: counts cycles without memReady and flags when the
// configured limit is reached. Saturates instead of wrapping.
module sc_proc_wait_timer
  import sc_proc_mem_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic tick_i,
  output logic expired_o
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q >= LIMIT);

endmodule

// File: rtl/sc_proc_mem_seq.sv
// Multi-cycle instruction sequencer sharing one memory port between
// instruction fetch and load/store, with commit strobe and access timeout.
module sc_proc_mem_seq
  import sc_proc_mem_seq_pkg::*;
#(
  parameter int unsigned DBITS   = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DBITS-1:0] pcOut,
  input  logic             isMemOp,
  input  logic             isSW,
  input  logic [DBITS-1:0] dAddr,
  input  logic [DBITS-1:0] dWdata,
  input  logic             halt,
  output logic             memReq,
  output logic             memWe,
  output logic [DBITS-1:0] memAddr,
  output logic [DBITS-1:0] memWdata,
  input  logic [DBITS-1:0] memRdata,
  input  logic             memReady,
  output logic [DBITS-1:0] instr,
  output logic [DBITS-1:0] outMem,
  output logic             lock,
  output logic             halted,
  output logic             memErr,
  output logic [31:0]      retired,
  output logic [2:0]       dbg_state_o
);

  state_t           state_q, state_d;
  logic [DBITS-1:0] instr_q, instr_d;
  logic [DBITS-1:0] out_mem_q, out_mem_d;
  logic [DBITS-1:0] daddr_q, daddr_d;
  logic [DBITS-1:0] dwdata_q, dwdata_d;
  logic             is_sw_q, is_sw_d;
  logic [31:0]      retired_q, retired_d;
  logic             halted_q, halted_d;
  logic             mem_err_q, mem_err_d;

  logic access;
  logic expired;
  logic timer_clear;
  logic timer_tick;

  // Port handshake: memReq is a valid that stays high, with memAddr/memWe/
  // memWdata held constant, until memReady is sampled high on a rising edge;
  // that edge completes the transfer and memReq is low in the next cycle.
  // memReady is only looked at while memReq is high.
  assign access = is_access(state_q);

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    out_mem_d = out_mem_q;
    daddr_d   = daddr_q;
    dwdata_d  = dwdata_q;
    is_sw_d   = is_sw_q;
    retired_d = retired_q;
    mem_err_d = mem_err_q;
    case (state_q)
      ST_FETCH: begin
        if (memReady) begin
          instr_d = memRdata;
          state_d = ST_EXEC;
        end else if (expired) begin
          mem_err_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_EXEC: begin
        daddr_d  = dAddr;
        dwdata_d = dWdata;
        is_sw_d  = isSW;
        state_d  = isMemOp ? ST_DATA : ST_COMMIT;
      end
      ST_DATA: begin
        // Completion takes priority over a timeout expiring in the same cycle.
        if (memReady) begin
          if (!is_sw_q) begin
            out_mem_d = memRdata;
          end
          state_d = ST_COMMIT;
        end else if (expired) begin
          mem_err_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_COMMIT: begin
        retired_d = retired_q + 32'd1;
        state_d   = halt ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  assign halted_d = halted_q | (state_d == ST_HALT);

  // The counter restarts whenever a new access begins.
  assign timer_clear = (state_d != state_q) && is_access(state_d);
  assign timer_tick  = access && !memReady;

  sc_proc_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (timer_clear),
    .tick_i   (timer_tick),
    .expired_o(expired)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_FETCH;
      instr_q   <= '0;
      out_mem_q <= '0;
      daddr_q   <= '0;
      dwdata_q  <= '0;
      is_sw_q   <= 1'b0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      out_mem_q <= out_mem_d;
      daddr_q   <= daddr_d;
      dwdata_q  <= dwdata_d;
      is_sw_q   <= is_sw_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Request and commit strobes are masked while reset is held so that a reset
  // arriving mid-access drops the port immediately.
  assign memReq   = reset_n && access;
  assign memWe    = reset_n && (state_q == ST_DATA) && is_sw_q;
  assign memAddr  = (state_q == ST_DATA) ? daddr_q : pcOut;
  assign memWdata = dwdata_q;
  assign lock     = reset_n && (state_q == ST_COMMIT);

  assign instr       = instr_q;
  assign outMem      = out_mem_q;
  assign retired     = retired_q;
  assign halted      = halted_q;
  assign memErr      = mem_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sc_proc_mem_seq.sv
// Bench for sc_proc_mem_seq: programs are expanded into a per-cycle timeline
// of expected port activity and architectural outputs, compared every cycle.
module tb_sc_proc_mem_seq;
  import sc_proc_mem_seq_pkg::*;

  localparam int TO   = 8;
  localparam int MAXC = 80;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pcOut = '0, dAddr = '0, dWdata = '0, memRdata = '0;
  logic        isMemOp = 1'b0, isSW = 1'b0, halt = 1'b0, memReady = 1'b0;
  logic        memReq, memWe, lock, halted, memErr;
  logic [31:0] memAddr, memWdata, instr, outMem, retired;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  sc_proc_mem_seq #(.DBITS(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .pcOut(pcOut), .isMemOp(isMemOp), .isSW(isSW),
    .dAddr(dAddr), .dWdata(dWdata), .halt(halt), .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memWdata(memWdata), .memRdata(memRdata), .memReady(memReady),
    .instr(instr), .outMem(outMem), .lock(lock), .halted(halted), .memErr(memErr),
    .retired(retired), .dbg_state_o(dbg_state)
  );

  // ---------------- program and timeline model ----------------
  typedef struct {
    logic [31:0] word;
    int          fd;
    bit          mem;
    bit          sw;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] rdata;
    int          dd;
    bit          hx;
    bit          hc;
  } ins_t;
  ins_t prog_q[$];

  logic        exp_req [MAXC], exp_we [MAXC], exp_lock [MAXC], exp_hl [MAXC], exp_er [MAXC];
  logic [31:0] exp_addr [MAXC], exp_wdata [MAXC], exp_ret [MAXC], exp_ins [MAXC], exp_om [MAXC];
  logic        drv_rdy [MAXC], drv_ismem [MAXC], drv_issw [MAXC], drv_halt [MAXC];
  logic [31:0] drv_pc [MAXC], drv_rdata [MAXC], drv_daddr [MAXC], drv_dwdata [MAXC];

  int          c, len;
  logic [31:0] m_pc, m_ret, m_ins, m_om;
  bit          m_hl, m_er;

  // ---------------- scoreboard state ----------------
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, rst_edges = 0;
  bit          checking = 1'b0, in_reset = 1'b0;
  int          lock_q[$];
  logic [31:0] exp_q[$];
  int          req_cnt, we_cnt, addr_hits;
  logic [31:0] we_addr, we_data, watch_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp_v);
    end
  endtask

  task automatic add(input logic [31:0] word, input int fd, input bit mem, input bit sw,
                     input logic [31:0] daddr, input logic [31:0] dwdata,
                     input logic [31:0] rdata, input int dd, input bit hx, input bit hc);
    ins_t e;
    e.word = word; e.fd = fd; e.mem = mem; e.sw = sw; e.daddr = daddr;
    e.dwdata = dwdata; e.rdata = rdata; e.dd = dd; e.hx = hx; e.hc = hc;
    prog_q.push_back(e);
  endtask

  // Record what cycle c must look like, given the model state before its edge.
  task automatic emit(input bit req, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit lk);
    if (c >= MAXC) begin
      $display("FAIL timeline_overflow cyc=%0d got=%0d exp=<%0d", c, c, MAXC);
      $fatal(1, "timeline too long");
    end
    exp_req[c] = req;  exp_we[c] = we;  exp_addr[c] = addr;  exp_wdata[c] = wdata;
    exp_lock[c] = lk;  exp_ret[c] = m_ret;  exp_ins[c] = m_ins;  exp_om[c] = m_om;
    exp_hl[c] = m_hl;  exp_er[c] = m_er;
    drv_pc[c] = m_pc;  drv_rdy[c] = 1'b0;  drv_rdata[c] = $urandom;
    drv_ismem[c] = 1'($urandom_range(0, 1));  drv_issw[c] = 1'($urandom_range(0, 1));
    drv_daddr[c] = $urandom;  drv_dwdata[c] = $urandom;  drv_halt[c] = 1'b0;
  endtask

  // One memory access: answered after dly wait cycles, or abandoned after TO waits.
  task automatic gen_access(input logic [31:0] addr, input bit we, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int dly, output bit done);
    done = 1'b0;
    for (int k = 0; k <= TO; k++) begin
      emit(1'b1, we, addr, wdata, 1'b0);
      if (k == dly) begin
        drv_rdy[c] = 1'b1;
        drv_rdata[c] = rdata;
        c++;
        done = 1'b1;
        break;
      end
      c++;
      if (k == TO) begin
        m_er = 1'b1;
        m_hl = 1'b1;
        break;
      end
    end
  endtask

  task automatic build();
    bit ok;
    c = 1; m_pc = 32'h1000; m_ret = 0; m_ins = 0; m_om = 0; m_hl = 0; m_er = 0;
    foreach (prog_q[i]) begin
      if (m_hl) continue;
      gen_access(m_pc, 1'b0, 32'h0, prog_q[i].word, prog_q[i].fd, ok);
      if (!ok) continue;
      m_ins = prog_q[i].word;
      emit(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      drv_ismem[c] = prog_q[i].mem;  drv_issw[c] = prog_q[i].sw;
      drv_daddr[c] = prog_q[i].daddr;  drv_dwdata[c] = prog_q[i].dwdata;
      drv_halt[c] = prog_q[i].hx;  drv_rdy[c] = 1'b1;
      c++;
      if (prog_q[i].mem) begin
        gen_access(prog_q[i].daddr, prog_q[i].sw, prog_q[i].dwdata, prog_q[i].rdata,
                   prog_q[i].dd, ok);
        if (!ok) continue;
        if (!prog_q[i].sw) m_om = prog_q[i].rdata;
      end
      emit(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      drv_halt[c] = prog_q[i].hc;  drv_rdy[c] = 1'b1;
      c++;
      m_ret++;  m_pc += 32'd4;
      if (prog_q[i].hc) m_hl = 1'b1;
    end
    for (int t = 0; t < 6; t++) begin
      if (m_hl) begin
        emit(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drv_rdy[c] = 1'b1;
      end else begin
        emit(1'b1, 1'b0, m_pc, 32'h0, 1'b0);
      end
      c++;
    end
    len = c - 1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input int k);
    pcOut = drv_pc[k];  memReady = drv_rdy[k];  memRdata = drv_rdata[k];
    isMemOp = drv_ismem[k];  isSW = drv_issw[k];  dAddr = drv_daddr[k];
    dWdata = drv_dwdata[k];  halt = drv_halt[k];
  endtask

  task automatic run_test(input int cut);
    int lim;
    lock_q.delete();
    req_cnt = 0; we_cnt = 0; addr_hits = 0; we_addr = '0; we_data = '0;
    build();
    reset_n = 1'b0; in_reset = 1'b1; rst_edges = 0; checking = 1'b0;
    memReady = 1'b1; memRdata = $urandom; halt = 1'b1; isMemOp = 1'b1; isSW = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      rst_edges++;
      memRdata = $urandom;
    end
    lim = (cut > 0 && cut < len) ? cut : len;
    in_reset = 1'b0;
    reset_n = 1'b1;
    for (int k = 1; k <= lim; k++) begin
      drive(k);
      cyc = k;
      checking = 1'b1;
      @(posedge clk); #1;
    end
    checking = 1'b0;
    prog_q.delete();
  endtask

  task automatic check_locks(input int n, input int l0, input int l1, input int l2);
    exp_q.delete();
    if (n > 0) exp_q.push_back(l0);
    if (n > 1) exp_q.push_back(l1);
    if (n > 2) exp_q.push_back(l2);
    check("lock_count", lock_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < lock_q.size()) check("lock_cycle", lock_q[i], exp_q[i]);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (in_reset) begin
      check("rst_memReq", 32'(memReq), 32'h0);
      check("rst_lock", 32'(lock), 32'h0);
      if (rst_edges >= 1) begin
        check("rst_retired", retired, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_outMem", outMem, 32'h0);
        check("rst_flags", {30'b0, halted, memErr}, 32'h0);
        check("rst_state", 32'(dbg_state), 32'(ST_FETCH));
      end
    end else if (checking) begin
      check("memReq", 32'(memReq), 32'(exp_req[cyc]));
      check("lock", 32'(lock), 32'(exp_lock[cyc]));
      if (exp_req[cyc]) begin
        check("memAddr", memAddr, exp_addr[cyc]);
        check("memWe", 32'(memWe), 32'(exp_we[cyc]));
        if (exp_we[cyc]) check("memWdata", memWdata, exp_wdata[cyc]);
      end
      check("instr", instr, exp_ins[cyc]);
      check("outMem", outMem, exp_om[cyc]);
      check("retired", retired, exp_ret[cyc]);
      check("halted", 32'(halted), 32'(exp_hl[cyc]));
      check("memErr", 32'(memErr), 32'(exp_er[cyc]));
      if (lock) lock_q.push_back(cyc);
      if (memReq) req_cnt++;
      if (memReq && memWe) begin
        we_cnt++;
        we_addr = memAddr;
        we_data = memWdata;
      end
      if (memReq && memAddr == watch_addr) addr_hits++;
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    watch_addr = 32'hFFFF_FFFF;
    @(posedge clk); #1;

    // Three ALU instructions, zero-wait memory.
    add(32'h0000_0013, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    add(32'h0010_0093, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    add(32'h0020_8113, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    run_test(0);
    check_locks(3, 3, 6, 9);
    check("t1_retired", retired, 32'd3);

    // Load with two wait cycles in DATA.
    watch_addr = 32'h0000_0200;
    add(32'hA000_0003, 0, 1, 0, 32'h200, 32'h0, 32'hCAFE_F00D, 2, 0, 0);
    run_test(0);
    check("t2_addr_held", addr_hits, 32'd3);
    check("t2_outMem", outMem, 32'hCAFE_F00D);
    check("t2_writes", we_cnt, 32'd0);
    check_locks(1, 4 + 2, 0, 0);

    // Load then store; the store must not disturb outMem.
    add(32'hB000_0003, 1, 1, 0, 32'h300, 32'h0, 32'h1111_2222, 1, 0, 0);
    add(32'hB100_0023, 0, 1, 1, 32'h100, 32'hDEAD_BEEF, 32'h9999_9999, 0, 0, 0);
    run_test(0);
    check("t3_we_cnt", we_cnt, 32'd1);
    check("t3_we_addr", we_addr, 32'h0000_0100);
    check("t3_we_data", we_data, 32'hDEAD_BEEF);
    check("t3_outMem", outMem, 32'h1111_2222);

    // Fetch never answered.
    add(32'hC000_0013, -1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    run_test(0);
    check("t4_memErr", 32'(memErr), 32'h1);
    check("t4_halted", 32'(halted), 32'h1);
    check("t4_req_cycles", req_cnt, 32'd9);
    check_locks(0, 0, 0, 0);

    // halt pulsed in EXEC is ignored; halt at COMMIT stops.
    add(32'hD000_0013, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 0);
    add(32'hD100_0003, 0, 1, 0, 32'h240, 32'h0, 32'h55AA_55AA, 0, 0, 1);
    run_test(0);
    check_locks(2, 3, 7, 0);
    check("t5_retired", retired, 32'd2);
    check("t5_halted", 32'(halted), 32'h1);
    check("t5_memReq", 32'(memReq), 32'h0);

    // Reset dropped in the middle of a DATA wait (next test's reset).
    add(32'hE000_0003, 0, 1, 0, 32'h280, 32'h0, 32'h7777_7777, 6, 0, 0);
    run_test(5);
    check_locks(0, 0, 0, 0);

    // Ready arriving on the timeout cycle wins, in FETCH and in DATA.
    add(32'hF000_0013, 8, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    add(32'hF100_0003, 0, 1, 0, 32'h2C0, 32'h0, 32'h0BAD_C0DE, 8, 0, 1);
    run_test(0);
    check_locks(2, 11, 23, 0);
    check("t7_memErr", 32'(memErr), 32'h0);
    check("t7_retired", retired, 32'd2);
    check("t7_outMem", outMem, 32'h0BAD_C0DE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
